// File: rtl/mcr_dl_pkg.sv
// Shared types and helpers for the MCR ROM-download path: FSM states, the
// region decode function and the default Tapper region map.
package mcr_dl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dl_state_t;

    localparam int MAX_NREG = 8;
    localparam int MAX_AW   = 32;
    localparam int IDX_W    = 3;

    // Bases padded to the widest supported map so one function serves every instance
    typedef logic [MAX_NREG*MAX_AW-1:0] base_tbl_t;

    localparam int TAPPER_NREG = 4;
    localparam int TAPPER_AW   = 25;
    localparam logic [TAPPER_NREG*TAPPER_AW-1:0] TAPPER_BASES =
        {25'h32000, 25'h12000, 25'h0E000, 25'h00000};

    // Highest region whose base is <= addr; relies on bases being ascending.
    function automatic logic [IDX_W-1:0] region_of(input logic [MAX_AW-1:0] addr,
                                                   input base_tbl_t          bases,
                                                   input int                 nreg);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 1; i < MAX_NREG; i++) begin
            if (i < nreg && addr >= bases[i*MAX_AW +: MAX_AW])
                idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rom_dl_router_if.sv
// HPS ioctl byte stream on one side, per-region toggle req/ack write ports on the other.
interface rom_dl_router_if #(
    parameter int NREG = 4,
    parameter int AW   = 25
);
    logic            ioctl_download;
    logic            ioctl_wr;
    logic [AW-1:0]   ioctl_addr;
    logic [7:0]      ioctl_dout;
    logic            ioctl_wait;
    logic [NREG-1:0] reg_req;
    logic [NREG-1:0] reg_ack;
    logic [AW-1:0]   reg_addr;
    logic [1:0]      reg_ds;
    logic [15:0]     reg_d;
    logic [NREG-1:0] reg_sel;

    // Router side
    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, reg_ack,
        output ioctl_wait, reg_req, reg_addr, reg_ds, reg_d, reg_sel
    );

    // HPS and memory side
    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, reg_ack,
        input  ioctl_wait, reg_req, reg_addr, reg_ds, reg_d, reg_sel
    );

endinterface

// File: rtl/dl_reset_gen.sv
// Core reset generator: continuous reset while not ready, then one extra
// single-cycle pulse RST_CNT-1 cycles after release.
module dl_reset_gen #(
    parameter logic [15:0] RST_CNT = 16'hFFFF
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic rst_req,
    input  logic rom_loaded,
    input  logic ioctl_download,
    output logic core_reset
);

    logic        hold;
    logic [15:0] cnt_q;
    logic        core_reset_q;

    assign hold = RESET | rst_req | ~rom_loaded | ioctl_download;

    // RESET is part of hold, so the counter and output need no separate reset branch
    always_ff @(posedge clk_sys) begin
        // NOTE: state is updated with <= so every register samples pre-edge values.
        if (hold)
            cnt_q <= RST_CNT;
        else if (cnt_q != 16'd0)
            cnt_q <= cnt_q - 16'd1;
        core_reset_q <= hold | (cnt_q == 16'd1);
    end

    assign core_reset = core_reset_q;

endmodule

// File: rtl/rom_dl_router.sv
// Routes HPS ioctl download bytes to NREG memory regions over toggle req/ack
// handshakes, with back-pressure, ack timeout, load tracking and core reset.
module rom_dl_router
    import mcr_dl_pkg::*;
#(
    parameter int                   NREG     = 4,
    parameter int                   AW       = 25,
    parameter logic [NREG*AW-1:0]   REG_BASE = TAPPER_BASES,
    parameter logic [15:0]          RST_CNT  = 16'hFFFF,
    parameter int                   TMO_W    = 10
) (
    input  logic            clk_sys,
    input  logic            RESET,
    input  logic            rst_req,
    rom_dl_router_if.slave  bus,
    output logic            rom_loaded,
    output logic            dl_err,
    output logic            core_reset
);

    localparam int TMO_MAX = 2**TMO_W - 1;

    base_tbl_t        base_pad;
    logic [IDX_W-1:0] dec_idx;
    logic [AW-1:0]    dec_off;
    logic [NREG-1:0]  dec_sel;

    dl_state_t        state_q, state_d;
    logic             wr_q, dl_q, fall_pend_q, rom_loaded_q;
    logic             strobe, ack_done;
    logic [NREG-1:0]  req_q, req_d, sel_q, sel_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [1:0]       ds_q, ds_d;
    logic [15:0]      d_q, d_d;
    logic             wait_q, wait_d;
    logic             err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        base_pad = '0;
        for (int i = 0; i < NREG; i++)
            base_pad[i*MAX_AW +: MAX_AW] = MAX_AW'(REG_BASE[i*AW +: AW]);
    end

    always_comb begin
        dec_idx = region_of(MAX_AW'(bus.ioctl_addr), base_pad, NREG);
        // Offset wraps modulo 2**AW by truncation
        dec_off = bus.ioctl_addr - AW'(base_pad[dec_idx*MAX_AW +: MAX_AW]);
        for (int i = 0; i < NREG; i++)
            dec_sel[i] = (dec_idx == IDX_W'(i));
    end

    assign strobe   = bus.ioctl_wr & ~wr_q & bus.ioctl_download;
    assign ack_done = ((bus.reg_ack ^ req_q) & sel_q) == '0;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d = state_q;
        req_d   = req_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        ds_d    = ds_q;
        d_d     = d_q;
        wait_d  = wait_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    addr_d  = dec_off;
                    ds_d    = {bus.ioctl_addr[0], ~bus.ioctl_addr[0]};
                    d_d     = {bus.ioctl_dout, bus.ioctl_dout};
                    sel_d   = dec_sel;
                    req_d   = req_q ^ dec_sel;
                    wait_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Strobes here are ignored; HPS is held off by ioctl_wait
                if (ack_done) begin
                    wait_d  = 1'b0;
                    sel_d   = '0;
                    state_d = IDLE;
                end else if (tmo_q == TMO_W'(TMO_MAX - 1)) begin
                    // Give up on this write: the toggled req is left as is
                    err_d   = 1'b1;
                    wait_d  = 1'b0;
                    sel_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            dl_q         <= 1'b0;
            fall_pend_q  <= 1'b0;
            rom_loaded_q <= 1'b0;
            req_q        <= '0;
            sel_q        <= '0;
            addr_q       <= '0;
            ds_q         <= '0;
            d_q          <= '0;
            wait_q       <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= bus.ioctl_wr;
            dl_q    <= bus.ioctl_download;
            req_q   <= req_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            ds_q    <= ds_d;
            d_q     <= d_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            // A download end only counts once any outstanding write has been acked
            if (dl_q && !bus.ioctl_download)
                fall_pend_q <= 1'b1;
            else if (fall_pend_q && !bus.ioctl_download && state_q == IDLE) begin
                fall_pend_q  <= 1'b0;
                rom_loaded_q <= 1'b1;
            end
        end
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.reg_req    = req_q;
    assign bus.reg_sel    = sel_q;
    assign bus.reg_addr   = addr_q;
    assign bus.reg_ds     = ds_q;
    assign bus.reg_d      = d_q;
    assign rom_loaded     = rom_loaded_q;
    assign dl_err         = err_q;

    dl_reset_gen #(
        .RST_CNT (RST_CNT)
    ) u_reset_gen (
        .clk_sys        (clk_sys),
        .RESET          (RESET),
        .rst_req        (rst_req),
        .rom_loaded     (rom_loaded_q),
        .ioctl_download (bus.ioctl_download),
        .core_reset     (core_reset)
    );

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed bench for rom_dl_router: routing table, handshake, timeout,
// end-of-download and delayed core reset pulses.
module tb_rom_dl_router;
    import mcr_dl_pkg::*;

    logic clk_sys = 1'b0;
    logic RESET;
    logic rst_req;
    logic rom_loaded, dl_err, core_reset;

    int n_vec = 0;
    int n_mis = 0;

    logic [3:0] req_m = '0;
    logic [3:0] ack_m = '0;

    rom_dl_router_if #(.NREG(4), .AW(25)) bus ();

    rom_dl_router #(
        .NREG     (4),
        .AW       (25),
        .REG_BASE (TAPPER_BASES),
        .RST_CNT  (16'd16),
        .TMO_W    (4)
    ) dut (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .rst_req    (rst_req),
        .bus        (bus),
        .rom_loaded (rom_loaded),
        .dl_err     (dl_err),
        .core_reset (core_reset)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [3:0]  sel;
        logic [24:0] off;
        logic [1:0]  ds;
        logic [15:0] d;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [24:0] addr, input logic [7:0] data);
        bus.ioctl_addr = addr;
        bus.ioctl_dout = data;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic count_to_pulse(input string name);
        int n;
        n = 0;
        while (!core_reset && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(n), 32'd15);
        tick();
        check({name, "_width"}, 32'(core_reset), 32'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{25'h0012005, 8'hA5, 4'b0100, 25'h0000005, 2'b10, 16'hA5A5};
        vecs[1] = '{25'h000DFFF, 8'h3C, 4'b0001, 25'h000DFFF, 2'b10, 16'h3C3C};
        vecs[2] = '{25'h000E000, 8'h11, 4'b0010, 25'h0000000, 2'b01, 16'h1111};
        vecs[3] = '{25'h0011FFF, 8'h7E, 4'b0010, 25'h0003FFF, 2'b10, 16'h7E7E};
        vecs[4] = '{25'h0032000, 8'hC3, 4'b1000, 25'h0000000, 2'b01, 16'hC3C3};
        vecs[5] = '{25'h1FFFFFF, 8'h5A, 4'b1000, 25'h1FCDFFF, 2'b10, 16'h5A5A};
        vecs[6] = '{25'h0000000, 8'h00, 4'b0001, 25'h0000000, 2'b01, 16'h0000};

        RESET              = 1'b1;
        rst_req            = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.reg_ack        = ack_m;
        repeat (3) tick();

        check("rst_req",        32'(bus.reg_req),    32'h0);
        check("rst_sel",        32'(bus.reg_sel),    32'h0);
        check("rst_addr",       32'(bus.reg_addr),   32'h0);
        check("rst_ds",         32'(bus.reg_ds),     32'h0);
        check("rst_d",          32'(bus.reg_d),      32'h0);
        check("rst_wait",       32'(bus.ioctl_wait), 32'h0);
        check("rst_rom_loaded", 32'(rom_loaded),     32'h0);
        check("rst_dl_err",     32'(dl_err),         32'h0);
        check("rst_core_reset", 32'(core_reset),     32'h1);

        RESET = 1'b0;
        bus.ioctl_download = 1'b1;
        tick();

        // Routing table: strobe, check latched request, then ack it
        for (int i = 0; i < 7; i++) begin
            strobe(vecs[i].addr, vecs[i].data);
            req_m = req_m ^ vecs[i].sel;
            check($sformatf("v%0d_req", i),  32'(bus.reg_req),    32'(req_m));
            check($sformatf("v%0d_sel", i),  32'(bus.reg_sel),    32'(vecs[i].sel));
            check($sformatf("v%0d_addr", i), 32'(bus.reg_addr),   32'(vecs[i].off));
            check($sformatf("v%0d_ds", i),   32'(bus.reg_ds),     32'(vecs[i].ds));
            check($sformatf("v%0d_d", i),    32'(bus.reg_d),      32'(vecs[i].d));
            check($sformatf("v%0d_wait", i), 32'(bus.ioctl_wait), 32'h1);
            ack_m = req_m;
            bus.reg_ack = ack_m;
            tick();
            check($sformatf("v%0d_wait_done", i), 32'(bus.ioctl_wait), 32'h0);
            check($sformatf("v%0d_sel_done", i),  32'(bus.reg_sel),    32'h0);
        end

        // Slow ack with a stray strobe while waiting
        strobe(25'h0012005, 8'hA5);
        req_m[2] = ~req_m[2];
        check("hs_req", 32'(bus.reg_req), 32'(req_m));
        for (int j = 1; j < 7; j++) begin
            bus.ioctl_wr   = (j == 2);
            bus.ioctl_addr = 25'h000DFFF;
            tick();
            check($sformatf("hs_wait_%0d", j), 32'(bus.ioctl_wait), 32'h1);
        end
        bus.ioctl_wr = 1'b0;
        check("hs_no_extra_req", 32'(bus.reg_req),  32'(req_m));
        check("hs_addr_held",    32'(bus.reg_addr), 32'h5);
        check("hs_sel_held",     32'(bus.reg_sel),  32'h4);
        tick();
        check("hs_wait_7", 32'(bus.ioctl_wait), 32'h1);
        ack_m[2] = ~ack_m[2];
        bus.reg_ack = ack_m;
        tick();
        check("hs_wait_drop", 32'(bus.ioctl_wait), 32'h0);
        check("hs_req_final", 32'(bus.reg_req),    32'(req_m));

        // Ack never arrives: 15 cycles in WAIT, then error
        strobe(25'h0032010, 8'h99);
        req_m[3] = ~req_m[3];
        check("tmo_req", 32'(bus.reg_req), 32'(req_m));
        repeat (14) tick();
        check("tmo_err_early",  32'(dl_err),         32'h0);
        check("tmo_wait_early", 32'(bus.ioctl_wait), 32'h1);
        tick();
        check("tmo_err",       32'(dl_err),         32'h1);
        check("tmo_wait_drop", 32'(bus.ioctl_wait), 32'h0);
        ack_m[3] = ~ack_m[3];
        bus.reg_ack = ack_m;
        strobe(25'h0012006, 8'h42);
        req_m[2] = ~req_m[2];
        check("tmo_next_req",  32'(bus.reg_req),    32'(req_m));
        check("tmo_next_wait", 32'(bus.ioctl_wait), 32'h1);
        check("tmo_next_addr", 32'(bus.reg_addr),   32'h6);
        ack_m[2] = ~ack_m[2];
        bus.reg_ack = ack_m;
        tick();
        check("tmo_next_done", 32'(bus.ioctl_wait), 32'h0);

        // Download ends while a write is outstanding
        strobe(25'h0012007, 8'h77);
        req_m[2] = ~req_m[2];
        bus.ioctl_download = 1'b0;
        repeat (3) tick();
        check("eod_wait_held",   32'(bus.ioctl_wait), 32'h1);
        check("eod_not_loaded",  32'(rom_loaded),     32'h0);
        check("eod_core_reset",  32'(core_reset),     32'h1);
        ack_m[2] = ~ack_m[2];
        bus.reg_ack = ack_m;
        tick();
        check("eod_ack_wait",    32'(bus.ioctl_wait), 32'h0);
        check("eod_ack_loaded",  32'(rom_loaded),     32'h0);
        tick();
        check("eod_loaded",      32'(rom_loaded),     32'h1);
        check("eod_reset_hold",  32'(core_reset),     32'h1);
        tick();
        check("eod_reset_rel",   32'(core_reset),     32'h0);
        count_to_pulse("eod_repulse_gap");
        repeat (5) tick();
        check("eod_reset_quiet", 32'(core_reset),     32'h0);

        // User reset after load repeats the same shape
        rst_req = 1'b1;
        tick();
        check("rq_reset_high", 32'(core_reset), 32'h1);
        rst_req = 1'b0;
        tick();
        check("rq_reset_rel",  32'(core_reset), 32'h0);
        count_to_pulse("rq_repulse_gap");

        // New download after load keeps rom_loaded, holds core in reset
        bus.ioctl_download = 1'b1;
        tick();
        check("re_dl_reset",  32'(core_reset), 32'h1);
        check("re_dl_loaded", 32'(rom_loaded), 32'h1);
        bus.ioctl_download = 1'b0;
        repeat (2) tick();
        check("re_dl_rel",    32'(core_reset), 32'h0);
        check("re_dl_loaded2", 32'(rom_loaded), 32'h1);
        check("err_sticky",   32'(dl_err),     32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
